// File: rtl/tlb_miss_walker_if.sv
// Walker-facing bundle: miss request, flush, PTE memory port and TLB fill / fault outputs.
// master = core + memory side, slave = the walker.
interface tlb_miss_walker_if;
  logic        miss_valid;
  logic [31:0] miss_virt_addr;
  logic [31:0] ptbr;
  logic        flush;
  logic        busy;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        new_tlb_entry;
  logic [52:0] new_tlb_info;
  logic        walk_done;
  logic        page_fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_vaddr;

  modport master (
    output miss_valid, miss_virt_addr, ptbr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  busy, mem_req_valid, mem_req_addr, new_tlb_entry, new_tlb_info, walk_done,
           page_fault, fault_cause, fault_vaddr
  );

  modport slave (
    input  miss_valid, miss_virt_addr, ptbr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output busy, mem_req_valid, mem_req_addr, new_tlb_entry, new_tlb_info, walk_done,
           page_fault, fault_cause, fault_vaddr
  );
endinterface

// File: rtl/tlb_miss_walker.sv
// Single-level page-table walker: one PTE read per TLB miss, answering with a TLB fill or a page fault.
// All outputs decode from registered state; flush aborts and discards the in-flight PTE response.
module tlb_miss_walker #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  tlb_miss_walker_if.slave  bus
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, FAULT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   vaddr_q, ptbr_q;
  logic [CW-1:0] cnt_q;
  logic          drop_q;
  logic [52:0]   info_q;
  logic [31:0]   fvaddr_q;
  logic [1:0]    cause_q;
  logic          req_valid;
  logic          rsp_live;
  logic          timeout;
  logic          unused_pte_bits;

  assign req_valid       = (state_q == REQ) && !drop_q;
  assign rsp_live        = bus.mem_rsp_valid && !drop_q;
  assign timeout         = (cnt_q == LAST_CNT);
  assign unused_pte_bits = ^bus.mem_rsp_data[11:2];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.miss_valid) state_d = REQ;
      REQ:   if (req_valid && bus.mem_req_ready) state_d = WAIT;
      WAIT: begin
        // A response in the timeout cycle still counts.
        if (rsp_live)     state_d = bus.mem_rsp_data[0] ? FILL : FAULT;
        else if (timeout) state_d = FAULT;
      end
      FILL, FAULT: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      vaddr_q  <= '0;
      ptbr_q   <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      info_q   <= '0;
      fvaddr_q <= '0;
      cause_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.miss_valid && !bus.flush) begin
        vaddr_q <= bus.miss_virt_addr;
        ptbr_q  <= bus.ptbr;
      end
      cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      // Any request the memory has accepted owes us a response; discard it after a flush.
      if (drop_q && bus.mem_rsp_valid)
        drop_q <= 1'b0;
      else if (bus.flush && ((state_q == WAIT && !bus.mem_rsp_valid) ||
                             (req_valid && bus.mem_req_ready)))
        drop_q <= 1'b1;
      if (state_q == WAIT && !bus.flush) begin
        if (rsp_live && bus.mem_rsp_data[0]) begin
          info_q <= {vaddr_q[31:12], bus.mem_rsp_data[31:12], 12'b0, bus.mem_rsp_data[1]};
        end else if (rsp_live || timeout) begin
          fvaddr_q <= vaddr_q;
          cause_q  <= rsp_live ? 2'b01 : 2'b10;
        end
      end
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = ptbr_q + {10'b0, vaddr_q[31:12], 2'b00};
  assign bus.new_tlb_entry = (state_q == FILL);
  assign bus.walk_done     = (state_q == FILL);
  assign bus.new_tlb_info  = info_q;
  assign bus.page_fault    = (state_q == FAULT);
  assign bus.fault_cause   = (state_q == FAULT) ? cause_q : 2'b00;
  assign bus.fault_vaddr   = fvaddr_q;
endmodule

// File: tb/tb_tlb_miss_walker.sv
// Randomized and directed bench for tlb_miss_walker against a behavioural walk model.
`timescale 1ns/1ps
module tb_tlb_miss_walker;
  localparam int T = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tlb_miss_walker_if bus();
  tlb_miss_walker #(.TIMEOUT_CYCLES(T)) dut (.clock(clock), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // PTE byte address: table base plus 4 bytes per virtual page, modulo 2^32.
  function automatic logic [31:0] exp_addr(input logic [31:0] pt, input logic [31:0] va);
    logic [63:0] a;
    a = {32'b0, pt} + ({32'b0, va} / 64'd4096) * 64'd4;
    return a[31:0];
  endfunction

  // Fill word: vpn at bit 33, ppn at bit 13, W at bit 0.
  function automatic logic [52:0] exp_info(input logic [31:0] va, input logic [31:0] pte);
    logic [63:0] v;
    v = ({32'b0, va} / 64'd4096) * 64'h2_0000_0000
      + ({32'b0, pte} / 64'd4096) * 64'h2000
      + (({32'b0, pte} / 64'd2) % 64'd2);
    return v[52:0];
  endfunction

  // One complete walk from IDLE; returns one cycle after the answer pulse.
  task automatic do_walk(input logic [31:0] va, input logic [31:0] pt, input logic [31:0] pte,
                         input int rdly, input int rsp_dly, input bit rsp_en, input string tag);
    logic [31:0] a;
    a = exp_addr(pt, va);
    bus.miss_valid = 1'b1; bus.miss_virt_addr = va; bus.ptbr = pt;
    step();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s accept: busy=%b want 1", tag, bus.busy); end
    for (int i = 0; i <= rdly; i++) begin
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== a) begin
        errors++;
        $display("FAIL %s req[%0d]: valid=%b addr=%h want 1 %h", tag, i, bus.mem_req_valid, bus.mem_req_addr, a);
      end
      if (i == rdly) bus.mem_req_ready = 1'b1;
      else begin bus.miss_virt_addr = $urandom; bus.ptbr = $urandom; end
      step();
    end
    bus.mem_req_ready = 1'b0;
    if (rsp_en) begin
      for (int i = 0; i < rsp_dly; i++) begin
        checks++;
        if (bus.new_tlb_entry !== 1'b0 || bus.page_fault !== 1'b0) begin
          errors++;
          $display("FAIL %s wait[%0d]: entry=%b fault=%b want 0 0", tag, i, bus.new_tlb_entry, bus.page_fault);
        end
        step();
      end
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = pte;
      step();
      bus.mem_rsp_valid = 1'b0; bus.miss_valid = 1'b0;
      if (pte[0]) begin
        checks++;
        if (bus.new_tlb_entry !== 1'b1 || bus.walk_done !== 1'b1 || bus.page_fault !== 1'b0 ||
            bus.new_tlb_info !== exp_info(va, pte)) begin
          errors++;
          $display("FAIL %s fill: entry=%b done=%b fault=%b info=%h want 1 1 0 %h", tag,
                   bus.new_tlb_entry, bus.walk_done, bus.page_fault, bus.new_tlb_info, exp_info(va, pte));
        end
      end else begin
        checks++;
        if (bus.page_fault !== 1'b1 || bus.fault_cause !== 2'b01 || bus.fault_vaddr !== va ||
            bus.new_tlb_entry !== 1'b0 || bus.walk_done !== 1'b0) begin
          errors++;
          $display("FAIL %s invalid: fault=%b cause=%b vaddr=%h entry=%b want 1 01 %h 0", tag,
                   bus.page_fault, bus.fault_cause, bus.fault_vaddr, bus.new_tlb_entry, va);
        end
      end
    end else begin
      for (int i = 0; i < T; i++) begin
        checks++;
        if (bus.page_fault !== 1'b0) begin errors++; $display("FAIL %s early timeout at %0d: fault=%b want 0", tag, i, bus.page_fault); end
        step();
      end
      bus.miss_valid = 1'b0;
      checks++;
      if (bus.page_fault !== 1'b1 || bus.fault_cause !== 2'b10 || bus.fault_vaddr !== va || bus.new_tlb_entry !== 1'b0) begin
        errors++;
        $display("FAIL %s timeout: fault=%b cause=%b vaddr=%h entry=%b want 1 10 %h 0", tag,
                 bus.page_fault, bus.fault_cause, bus.fault_vaddr, bus.new_tlb_entry, va);
      end
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.new_tlb_entry !== 1'b0 || bus.page_fault !== 1'b0 || bus.fault_cause !== 2'b00) begin
      errors++;
      $display("FAIL %s after: busy=%b entry=%b fault=%b cause=%b want 0 0 0 00", tag,
               bus.busy, bus.new_tlb_entry, bus.page_fault, bus.fault_cause);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.mem_req_valid, bus.new_tlb_entry, bus.walk_done, bus.page_fault, bus.fault_cause} !== 7'b0 ||
        bus.mem_req_addr !== 32'h0 || bus.new_tlb_info !== 53'h0 || bus.fault_vaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b req=%b addr=%h info=%h fault=%b vaddr=%h want all 0",
               bus.busy, bus.mem_req_valid, bus.mem_req_addr, bus.new_tlb_info, bus.page_fault, bus.fault_vaddr);
    end
  endtask

  task automatic test_fill();
    logic [52:0] want;
    want = {20'h00003, 20'h00045, 12'h0, 1'b1};
    // Fill appears in the 4th cycle counting the accept cycle.
    do_walk(32'h0000_3ABC, 32'h0001_0000, 32'h0004_5003, 0, 0, 1'b1, "fill");
    checks++;
    if (bus.new_tlb_info !== want) begin errors++; $display("FAIL fill_hold: info=%h want %h", bus.new_tlb_info, want); end
  endtask

  task automatic test_fault_invalid();
    do_walk(32'h1234_5000, 32'h0002_0000, 32'h0004_5000, 0, 2, 1'b1, "invalid");
  endtask

  task automatic test_timeout();
    do_walk(32'hDEAD_B000, 32'h0003_0000, 32'h0, 1, 0, 1'b0, "timeout");
  endtask

  task automatic test_rsp_beats_timeout();
    do_walk(32'h0ABC_D123, 32'h0004_0000, 32'h7777_7001, 0, T - 1, 1'b1, "tie");
  endtask

  task automatic test_wrap();
    do_walk(32'h0000_5FFF, 32'hFFFF_FFF0, 32'h0000_1003, 0, 0, 1'b1, "wrap");
  endtask

  task automatic test_ready_stall();
    do_walk(32'h0040_0000, 32'h0010_0000, 32'hABCD_E001, 5, 1, 1'b1, "stall");
  endtask

  task automatic test_back_to_back();
    do_walk(32'h1111_1000, 32'h0005_0000, 32'h2222_2003, 0, 0, 1'b1, "b2b_a");
    do_walk(32'h3333_3000, 32'h0005_0000, 32'h4444_4000, 0, 0, 1'b1, "b2b_b");
  endtask

  task automatic test_flush();
    bus.miss_valid = 1'b1; bus.flush = 1'b1; bus.miss_virt_addr = 32'h5555_5000;
    step();
    bus.flush = 1'b0; bus.miss_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle: busy=%b want 0", bus.busy); end
    // Flush in REQ before any handshake leaves nothing to drop.
    bus.miss_valid = 1'b1;
    step();
    bus.flush = 1'b1; bus.miss_valid = 1'b0;
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL flush_req: busy=%b req=%b want 0 0", bus.busy, bus.mem_req_valid);
    end
    do_walk(32'h6666_6000, 32'h0006_0000, 32'h0009_9003, 0, 0, 1'b1, "after_flush_req");
  endtask

  task automatic test_flush_stale();
    logic [31:0] va2, pt2, pte2;
    va2 = 32'h0077_7000; pt2 = 32'h0008_0000; pte2 = 32'h000C_C001;
    bus.miss_valid = 1'b1; bus.miss_virt_addr = 32'h0066_6000; bus.ptbr = 32'h0007_0000;
    step();
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    step();
    bus.flush = 1'b1; bus.miss_valid = 1'b0;
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.new_tlb_entry !== 1'b0 || bus.page_fault !== 1'b0) begin
      errors++; $display("FAIL flush_wait: busy=%b entry=%b fault=%b want 0 0 0", bus.busy, bus.new_tlb_entry, bus.page_fault);
    end
    bus.miss_valid = 1'b1; bus.miss_virt_addr = va2; bus.ptbr = pt2;
    step();
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL stale_hold1: busy=%b req=%b want 1 0", bus.busy, bus.mem_req_valid);
    end
    step();
    checks++;
    if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL stale_hold2: req=%b want 0", bus.mem_req_valid); end
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hBAD0_0003;
    step();
    bus.mem_rsp_valid = 1'b0;
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== exp_addr(pt2, va2) || bus.new_tlb_entry !== 1'b0) begin
      errors++;
      $display("FAIL stale_drop: req=%b addr=%h entry=%b want 1 %h 0", bus.mem_req_valid, bus.mem_req_addr,
               bus.new_tlb_entry, exp_addr(pt2, va2));
    end
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    step();
    checks++;
    if (bus.new_tlb_entry !== 1'b0 || bus.page_fault !== 1'b0) begin
      errors++; $display("FAIL stale_unused: entry=%b fault=%b want 0 0", bus.new_tlb_entry, bus.page_fault);
    end
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = pte2;
    step();
    bus.mem_rsp_valid = 1'b0; bus.miss_valid = 1'b0;
    checks++;
    if (bus.new_tlb_entry !== 1'b1 || bus.new_tlb_info !== exp_info(va2, pte2)) begin
      errors++;
      $display("FAIL stale_fill: entry=%b info=%h want 1 %h", bus.new_tlb_entry, bus.new_tlb_info, exp_info(va2, pte2));
    end
    step();
  endtask

  task automatic test_reset_midwalk();
    bus.miss_valid = 1'b1; bus.miss_virt_addr = 32'h0099_9000; bus.ptbr = 32'h0009_0000;
    step();
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0; bus.miss_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.mem_req_valid, bus.new_tlb_entry, bus.page_fault, bus.fault_cause} !== 6'b0 ||
        bus.mem_req_addr !== 32'h0 || bus.new_tlb_info !== 53'h0 || bus.fault_vaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b req=%b addr=%h info=%h vaddr=%h want all 0",
               bus.busy, bus.mem_req_valid, bus.mem_req_addr, bus.new_tlb_info, bus.fault_vaddr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      do_walk($urandom, $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, T - 1)),
              ($urandom_range(0, 7) != 0), "rand");
    end
  endtask

  initial begin
    bus.miss_valid = 1'b0; bus.miss_virt_addr = '0; bus.ptbr = '0; bus.flush = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    test_reset();
    test_fill();
    test_fault_invalid();
    test_timeout();
    test_rsp_beats_timeout();
    test_wrap();
    test_ready_stall();
    test_back_to_back();
    test_flush();
    test_flush_stale();
    test_reset_midwalk();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
